// File: rtl/pattern_encoder.sv
// Transmit-side stream encoder: turns a 4-bit request mask into a sequence of
// code words, lowest bit first, each followed by GAP_CYCLES idle words.
module pattern_encoder #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [7:0]  CODE0      = 8'h0F,
  parameter logic [7:0]  CODE1      = 8'hF0,
  parameter logic [7:0]  CODE2      = 8'h3C,
  parameter logic [7:0]  CODE3      = 8'hC3
) (
  input  logic       clk_i,
  input  logic       rst_clk_i,
  input  logic [3:0] pattern_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] stream_o,
  output logic       busy_o,
  output logic       done_o
);

  if (GAP_CYCLES == 0 || GAP_CYCLES > 15) begin : g_bad_gap_cycles
    $error("pattern_encoder: GAP_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

  localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYCLES);
  localparam logic [3:0][7:0] CODES    = {CODE3, CODE2, CODE1, CODE0};

  state_t     state_reg, state_next;
  logic [3:0] pending_reg, pending_next;
  logic [3:0] gap_cnt_reg, gap_cnt_next;
  logic [7:0] stream_reg, stream_next;
  logic       ready_reg, ready_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  logic       accept;
  logic       gap_expire;
  logic [3:0] src_mask;
  logic [3:0] low_bit;
  logic [7:0] code_word;
  logic [7:0] code_term [4];

  assign accept     = valid_i && ready_reg;
  assign gap_expire = (state_reg == S_GAP) && (gap_cnt_reg == 4'd1);

  // The word for the next EMIT comes from the request itself when leaving
  // IDLE, otherwise from what is still pending.
  assign src_mask = (state_reg == S_IDLE) ? pattern_i : pending_reg;
  assign low_bit  = src_mask & (~src_mask + 4'd1);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_code_sel
    assign code_term[gi] = CODES[gi] & {8{low_bit[gi]}};
  end

  assign code_word = code_term[0] | code_term[1] | code_term[2] | code_term[3];

  // State register (also holds every registered output).
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      state_reg   <= S_IDLE;
      pending_reg <= 4'd0;
      gap_cnt_reg <= 4'd0;
      stream_reg  <= 8'h00;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      gap_cnt_reg <= gap_cnt_next;
      stream_reg  <= stream_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept && (pattern_i != 4'd0)) state_next = S_EMIT;
      S_EMIT: state_next = S_GAP;
      S_GAP:  if (gap_expire) state_next = (pending_reg != 4'd0) ? S_EMIT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: outputs are registered, so they are computed from the
  // state being entered.
  always_comb begin
    pending_next = pending_reg;
    gap_cnt_next = gap_cnt_reg;
    stream_next  = 8'h00;

    if (state_next == S_EMIT) begin
      stream_next  = code_word;
      pending_next = src_mask & ~low_bit;
    end

    if (state_reg == S_EMIT) begin
      gap_cnt_next = GAP_LOAD;
    end else if (state_reg == S_GAP) begin
      gap_cnt_next = gap_cnt_reg - 4'd1;
    end

    done_next  = (accept && (pattern_i == 4'd0)) ||
                 (gap_expire && (pending_reg == 4'd0));
    ready_next = (state_next == S_IDLE);
    busy_next  = (state_next != S_IDLE);
  end

  assign stream_o = stream_reg;
  assign ready_o  = ready_reg;
  assign busy_o   = busy_reg;
  assign done_o   = done_reg;

endmodule

// File: tb/tb_pattern_encoder.sv
// Bench for pattern_encoder: a frame-queue model checked every cycle plus
// directed sequences with literal expected words and done timing.
module tb_pattern_encoder;

  localparam int G = 2;

  logic       clk_i = 1'b0;
  logic       rst_clk_i;
  logic [3:0] pattern_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] stream_o;
  logic       busy_o;
  logic       done_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] codes [4] = '{8'h0F, 8'hF0, 8'h3C, 8'hC3};

  pattern_encoder #(.GAP_CYCLES(G)) dut (
    .clk_i     (clk_i),
    .rst_clk_i (rst_clk_i),
    .pattern_i (pattern_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .stream_o  (stream_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: an accepted request expands into a list of words to play
  // out; the frame is over when the list runs dry.
  logic [7:0] m_q [$];
  logic [7:0] m_stream = 8'h00;
  logic       m_ready  = 1'b1;
  logic       m_done   = 1'b0;

  initial begin
    forever begin
      @(posedge clk_i);
      if (rst_clk_i) begin
        m_q.delete();
        m_stream = 8'h00;
        m_ready  = 1'b1;
        m_done   = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_ready) begin
          if (valid_i) begin
            for (int k = 0; k < 4; k++) begin
              if (pattern_i[k]) begin
                m_q.push_back(codes[k]);
                for (int g = 0; g < G; g++) m_q.push_back(8'h00);
              end
            end
          end
          if (m_q.size() > 0) begin
            m_stream = m_q.pop_front();
            m_ready  = 1'b0;
          end else begin
            m_stream = 8'h00;
            m_done   = valid_i;
          end
        end else if (m_q.size() > 0) begin
          m_stream = m_q.pop_front();
        end else begin
          m_stream = 8'h00;
          m_ready  = 1'b1;
          m_done   = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle after the first edge.
  initial begin
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      chk("model_stream", stream_o, m_stream);
      chk("model_ready", {7'd0, ready_o}, {7'd0, m_ready});
      chk("model_busy", {7'd0, busy_o}, {7'd0, ~m_ready});
      chk("model_done", {7'd0, done_o}, {7'd0, m_done});
    end
  end

  task automatic expect_at(input string nm, input logic [7:0] s, input logic r, input logic d);
    chk({nm, "_stream"}, stream_o, s);
    chk({nm, "_ready"}, {7'd0, ready_o}, {7'd0, r});
    chk({nm, "_done"}, {7'd0, done_o}, {7'd0, d});
  endtask

  // Drives a request and returns at the first sample after the accepting edge.
  task automatic request(input logic [3:0] p);
    int n = 0;
    pattern_i = p;
    valid_i   = 1'b1;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("request_ready_timeout", {7'd0, ready_o}, 8'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("idle_timeout", {7'd0, ready_o}, 8'd1);
    @(negedge clk_i);
  endtask

  initial begin
    rst_clk_i = 1'b1;
    valid_i   = 1'b1;
    pattern_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      expect_at("reset", 8'h00, 1'b1, 1'b0);
      chk("reset_busy", {7'd0, busy_o}, 8'd0);
    end
    rst_clk_i = 1'b0;
    valid_i   = 1'b0;
    @(negedge clk_i);

    request(4'b0001);
    expect_at("b0001_0", 8'h0F, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b0001_1", 8'h00, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b0001_2", 8'h00, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b0001_3", 8'h00, 1'b1, 1'b1);
    @(negedge clk_i); expect_at("b0001_4", 8'h00, 1'b1, 1'b0);

    request(4'b1010);
    expect_at("b1010_0", 8'hF0, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b1010_1", 8'h00, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b1010_2", 8'h00, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b1010_3", 8'hC3, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b1010_4", 8'h00, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b1010_5", 8'h00, 1'b0, 1'b0);
    @(negedge clk_i); expect_at("b1010_6", 8'h00, 1'b1, 1'b1);
    @(negedge clk_i);

    request(4'b0000);
    expect_at("zero_0", 8'h00, 1'b1, 1'b1);
    @(negedge clk_i); expect_at("zero_1", 8'h00, 1'b1, 1'b0);

    // Full frame with a second request toggling underneath it.
    request(4'hF);
    expect_at("ff_0", 8'h0F, 1'b0, 1'b0);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk_i);
      if (i % 3 == 0) expect_at("ff_word", codes[i / 3], 1'b0, 1'b0);
      valid_i   = (i % 2) == 1;
      pattern_i = 4'b0100;
    end
    @(negedge clk_i);
    expect_at("ff_end", 8'h00, 1'b1, 1'b1);
    valid_i   = 1'b1;
    pattern_i = 4'b0100;
    @(negedge clk_i);
    expect_at("after_ff", 8'h3C, 1'b0, 1'b0);
    valid_i = 1'b0;
    wait_idle();

    // Reset two cycles into a frame.
    request(4'hF);
    expect_at("rst_mid_0", 8'h0F, 1'b0, 1'b0);
    @(negedge clk_i);
    expect_at("rst_mid_1", 8'h00, 1'b0, 1'b0);
    rst_clk_i = 1'b1;
    @(negedge clk_i);
    rst_clk_i = 1'b0;
    expect_at("rst_mid_2", 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      expect_at("rst_mid_quiet", 8'h00, 1'b1, 1'b0);
    end

    // Back-to-back requests, checked by the model.
    request(4'b0110);
    request(4'b0111);
    request(4'b1000);
    request(4'b0101);
    wait_idle();
    repeat (3) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
